// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: FSM state, register index,
// stage-control bundle and a saturating counter helper.
package cpu_types_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  // One bit per stage-register control, MSB first in this order.
  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic flush_ifid;
    logic flush_idex;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FREEZE   = stage_ctrl_t'(7'b00000_00);
  localparam stage_ctrl_t CTRL_NORMAL   = stage_ctrl_t'(7'b11111_00);
  localparam stage_ctrl_t CTRL_BRANCH   = stage_ctrl_t'(7'b11111_11);
  localparam stage_ctrl_t CTRL_LOAD_USE = stage_ctrl_t'(7'b00111_01);
  localparam stage_ctrl_t CTRL_JUMP     = stage_ctrl_t'(7'b11111_10);

  function automatic cnt_t sat_inc(input cnt_t value, input logic inc);
    return (inc && (value != CNT_MAX)) ? value + cnt_t'(1) : value;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_memren,
  input  reg_idx_t ex_rd,
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_uses_rt,
  output logic     load_use
);

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memren && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stall/flush steering, data-wait and halt FSM,
// and saturating cycle/stall performance counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dreq,
  input  logic        ex_memren,
  input  reg_idx_t    ex_rd,
  input  reg_idx_t    id_rs,
  input  reg_idx_t    id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        wb_halt,
  output logic        en_pc,
  output logic        en_ifid,
  output logic        en_idex,
  output logic        en_exmem,
  output logic        en_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        halt,
  output logic [15:0] cycle_cnt,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state
);

  pipe_state_t state_q, state_d;
  cnt_t        cycle_cnt_q, cycle_cnt_d;
  cnt_t        stall_cnt_q, stall_cnt_d;

  logic        load_use;
  logic        advance;
  logic        not_halted;
  stage_ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .ex_memren  (ex_memren),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    advance = 1'b0;
    state_d = state_q;

    case (state_q)
      RUN: begin
        advance = ihit && (!mem_dreq || dhit);
        if (advance && wb_halt) begin
          state_d = HALTED;
        end else if (mem_dreq && !dhit) begin
          state_d = DWAIT;
        end
      end
      DWAIT: begin
        advance = dhit;
        if (dhit) begin
          state_d = wb_halt ? HALTED : RUN;
        end
      end
      HALTED: begin
        advance = 1'b0;
      end
      default: begin
        advance = 1'b0;
        state_d = RUN;
      end
    endcase

    // Reset holds every stage register frozen regardless of the current state.
    if (RST) begin
      advance = 1'b0;
    end
  end

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (advance) begin
      if (ex_branch_taken) begin
        ctrl = CTRL_BRANCH;
      end else if (load_use) begin
        ctrl = CTRL_LOAD_USE;
      end else if (id_jump) begin
        ctrl = CTRL_JUMP;
      end else begin
        ctrl = CTRL_NORMAL;
      end
    end
  end

  assign not_halted  = (state_q != HALTED);
  assign cycle_cnt_d = sat_inc(cycle_cnt_q, not_halted);
  assign stall_cnt_d = sat_inc(stall_cnt_q, not_halted && !ctrl.en_pc);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign en_pc      = ctrl.en_pc;
  assign en_ifid    = ctrl.en_ifid;
  assign en_idex    = ctrl.en_idex;
  assign en_exmem   = ctrl.en_exmem;
  assign en_memwb   = ctrl.en_memwb;
  assign flush_ifid = ctrl.flush_ifid;
  assign flush_idex = ctrl.flush_idex;
  assign halt       = (state_q == HALTED);
  assign cycle_cnt  = cycle_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic
// compared against a flag-based behavioural model of the controller.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, mem_dreq, ex_memren, id_uses_rt;
  logic        ex_branch_taken, id_jump, wb_halt;
  reg_idx_t    ex_rd, id_rs, id_rt;
  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, halt;
  logic [15:0] cycle_cnt, stall_cnt;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Behavioural model: two flags and two plain integer counters.
  bit m_wait, m_halt;
  int m_cyc, m_stall;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .ex_memren(ex_memren), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .wb_halt(wb_halt),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .halt(halt), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .state(state)
  );

  always #5 CLK = ~CLK;

  logic [6:0]  act_ctrl;
  logic [41:0] act_all;
  assign act_ctrl = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex};
  assign act_all  = {act_ctrl, halt, state, cycle_cnt, stall_cnt};

  function automatic bit exp_adv();
    if (RST || m_halt) return 1'b0;
    if (m_wait) return dhit;
    return ihit && (!mem_dreq || dhit);
  endfunction

  function automatic logic [6:0] exp_ctrl();
    bit lu;
    lu = ex_memren && (ex_rd != 0) &&
         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    if (!exp_adv())      return 7'b00000_00;
    if (ex_branch_taken) return 7'b11111_11;
    if (lu)              return 7'b00111_01;
    if (id_jump)         return 7'b11111_10;
    return 7'b11111_00;
  endfunction

  function automatic logic [41:0] exp_all();
    logic [1:0] s;
    s = m_halt ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    return {exp_ctrl(), m_halt, s, m_cyc[15:0], m_stall[15:0]};
  endfunction

  task automatic model_edge();
    logic [6:0] c;
    bit a;
    c = exp_ctrl();
    a = exp_adv();
    if (RST) begin
      m_wait = 0; m_halt = 0; m_cyc = 0; m_stall = 0;
    end else if (!m_halt) begin
      if (m_cyc < 65535) m_cyc++;
      if (!c[6] && m_stall < 65535) m_stall++;
      if (a && wb_halt)             m_halt = 1;
      else if (m_wait)              m_wait = !dhit;
      else if (mem_dreq && !dhit)   m_wait = 1;
    end
  endtask

  // Advances one clock; entered and left just after a falling edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RST = 0; ihit = 1; dhit = 0; mem_dreq = 0; ex_memren = 0; id_uses_rt = 0;
    ex_branch_taken = 0; id_jump = 0; wb_halt = 0;
    ex_rd = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1; ex_memren = 1; ex_rd = 5'd3; id_rs = 5'd3;
    #1;
    checks++;
    if (act_ctrl !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", act_ctrl, 7'b0);
    end
    step();
    #1;
    checks++;
    if ({state, halt, cycle_cnt, stall_cnt, act_ctrl} !== 42'b0) begin
      errors++;
      $display("FAIL reset_state: state %0d halt %0d cyc %0d stall %0d ctrl %b expected all 0",
               state, halt, cycle_cnt, stall_cnt, act_ctrl);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_normal();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (act_ctrl !== 7'b11111_00) begin
        errors++; $display("FAIL normal_ctrl cyc %0d: got %b expected %b", i, act_ctrl, 7'b11111_00);
      end
      step();
    end
    #1;
    checks++;
    if (cycle_cnt !== 16'd10 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL normal_cnt: cyc %0d stall %0d expected 10 and 0", cycle_cnt, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] stall0;
    idle_inputs();
    stall0 = stall_cnt;
    ex_memren = 1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    checks++;
    if (act_ctrl !== 7'b00111_01) begin
      errors++; $display("FAIL load_use_rs: got %b expected %b", act_ctrl, 7'b00111_01);
    end
    step();
    #1;
    checks++;
    if (stall_cnt !== stall0 + 16'd1) begin
      errors++; $display("FAIL load_use_stall: got %0d expected %0d", stall_cnt, stall0 + 16'd1);
    end
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    checks++;
    if (act_ctrl !== 7'b11111_00) begin
      errors++; $display("FAIL load_use_r0: got %b expected %b", act_ctrl, 7'b11111_00);
    end
    step();
    ex_rd = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_uses_rt = 1;
    #1;
    checks++;
    if (act_ctrl !== 7'b00111_01) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", act_ctrl, 7'b00111_01);
    end
    id_uses_rt = 0;
    #1;
    checks++;
    if (act_ctrl !== 7'b11111_00) begin
      errors++; $display("FAIL load_use_rt_unused: got %b expected %b", act_ctrl, 7'b11111_00);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_branch_jump();
    logic [15:0] stall0;
    idle_inputs();
    stall0 = stall_cnt;
    ex_memren = 1; ex_rd = 5'd7; id_rs = 5'd7; ex_branch_taken = 1; id_jump = 1;
    #1;
    checks++;
    if (act_ctrl !== 7'b11111_11) begin
      errors++; $display("FAIL branch_over_lu: got %b expected %b", act_ctrl, 7'b11111_11);
    end
    step();
    #1;
    checks++;
    if (stall_cnt !== stall0) begin
      errors++; $display("FAIL branch_stall: got %0d expected %0d", stall_cnt, stall0);
    end
    ex_branch_taken = 0;
    #1;
    checks++;
    if (act_ctrl !== 7'b00111_01) begin
      errors++; $display("FAIL lu_over_jump: got %b expected %b", act_ctrl, 7'b00111_01);
    end
    ex_memren = 0;
    #1;
    checks++;
    if (act_ctrl !== 7'b11111_10) begin
      errors++; $display("FAIL jump: got %b expected %b", act_ctrl, 7'b11111_10);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_dwait();
    logic [15:0] stall0;
    idle_inputs();
    stall0 = stall_cnt;
    mem_dreq = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (act_ctrl !== 7'b0 || state !== (i == 0 ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL dwait_freeze cyc %0d: ctrl %b state %0d expected 0000000 state %0d",
                 i, act_ctrl, state, (i == 0 ? 0 : 1));
      end
      step();
    end
    ihit = 0; dhit = 1;
    #1;
    checks++;
    if (act_ctrl !== 7'b11111_00 || state !== 2'd1 || stall_cnt !== stall0 + 16'd3) begin
      errors++;
      $display("FAIL dwait_release: ctrl %b state %0d stall %0d expected 1111100 1 %0d",
               act_ctrl, state, stall_cnt, stall0 + 16'd3);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL dwait_return: got state %0d expected 0", state);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      RST             = ($urandom_range(63) == 0);
      ihit            = $urandom_range(3) != 0;
      dhit            = $urandom_range(1);
      mem_dreq        = $urandom_range(1);
      ex_memren       = $urandom_range(1);
      id_uses_rt      = $urandom_range(1);
      ex_branch_taken = ($urandom_range(5) == 0);
      id_jump         = ($urandom_range(4) == 0);
      ex_rd           = reg_idx_t'($urandom_range(3));
      id_rs           = reg_idx_t'($urandom_range(3));
      id_rt           = reg_idx_t'($urandom_range(3));
      #1;
      checks++;
      if (act_all !== exp_all()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, act_all, exp_all());
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    logic [15:0] cyc0;
    idle_inputs();
    wb_halt = 1;
    step();
    cyc0 = cycle_cnt;
    wb_halt = 0; ex_branch_taken = 1; dhit = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (halt !== 1'b1 || state !== 2'd2 || act_ctrl !== 7'b0 || cycle_cnt !== cyc0 ||
          act_all !== exp_all()) begin
        errors++;
        $display("FAIL halted cyc %0d: halt %0d state %0d ctrl %b cyc %0d expected 1 2 0000000 %0d",
                 i, halt, state, act_ctrl, cycle_cnt, cyc0);
      end
      step();
    end
    RST = 1;
    step();
    RST = 0; ex_branch_taken = 0; dhit = 0;
    #1;
    checks++;
    if (state !== 2'd0 || halt !== 1'b0 || cycle_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL halt_reset: state %0d halt %0d cyc %0d stall %0d expected all 0",
               state, halt, cycle_cnt, stall_cnt);
    end
    // Halt retiring while a data access completes out of DWAIT.
    mem_dreq = 1;
    step();
    step();
    dhit = 1; wb_halt = 1; ihit = 0;
    step();
    idle_inputs();
    #1;
    checks++;
    if (state !== 2'd2 || act_all !== exp_all()) begin
      errors++; $display("FAIL halt_from_dwait: got %h expected %h", act_all, exp_all());
    end
    RST = 1;
    step();
    #1;
    checks++;
    if (state !== 2'd0 || cycle_cnt !== 16'd0) begin
      errors++; $display("FAIL dwait_halt_reset: state %0d cyc %0d expected 0 0", state, cycle_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    RST = 1;
    step();
    RST = 0; ihit = 0;
    for (int i = 0; i < 70000; i++) step();
    #1;
    checks++;
    if (cycle_cnt !== 16'hFFFF || stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL saturate: cyc %h stall %h expected ffff ffff", cycle_cnt, stall_cnt);
    end
    step();
    step();
    #1;
    checks++;
    if (cycle_cnt !== 16'hFFFF || stall_cnt !== 16'hFFFF || act_all !== exp_all()) begin
      errors++; $display("FAIL saturate_hold: got %h expected %h", act_all, exp_all());
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge CLK);
    test_reset();
    test_normal();
    test_load_use();
    test_branch_jump();
    test_dwait();
    test_random();
    test_halt();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
